// File: rtl/riscv_dbiu_ahb.sv
// Data-side BIU: converts the biu_* strobe/ack handshake into pipelined AHB3-Lite single transfers.
// Latency: address accepted in cycle N, ack/err no earlier than N+1, plus one cycle per HREADY=0 cycle.
// Backpressure: HREADY=0 stalls both phases; the first ERROR cycle suppresses the next address phase.
module riscv_dbiu_ahb #(
    parameter int XLEN = 64,
    parameter int PLEN = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            biu_stb_i,
    output logic            biu_stb_ack_o,
    input  logic [PLEN-1:0] biu_adri_i,
    output logic [PLEN-1:0] biu_adro_o,
    input  logic [2:0]      biu_size_i,
    input  logic [2:0]      biu_type_i,
    input  logic            biu_lock_i,
    input  logic [2:0]      biu_prot_i,
    input  logic            biu_we_i,
    input  logic [XLEN-1:0] biu_d_i,
    output logic [XLEN-1:0] biu_q_o,
    output logic            biu_ack_o,
    output logic            biu_err_o,

    output logic [PLEN-1:0] HADDR,
    output logic [XLEN-1:0] HWDATA,
    input  logic [XLEN-1:0] HRDATA,
    output logic            HWRITE,
    output logic [2:0]      HSIZE,
    output logic [2:0]      HBURST,
    output logic [3:0]      HPROT,
    output logic [1:0]      HTRANS,
    output logic            HMASTLOCK,
    input  logic            HREADY,
    input  logic            HRESP
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // Data-phase state: the transfer whose address phase has already completed
    logic            r_dp_vld;
    logic            r_dp_we;
    logic [PLEN-1:0] r_dp_adr;
    logic [XLEN-1:0] r_dp_d;

    logic            w_kill;
    logic            w_req;
    logic            w_stb_ack;

    // First cycle of a two-cycle ERROR response: the slave requires the next
    // address phase to be IDLE, so the pending request is held off.
    assign w_kill    = r_dp_vld & HRESP & ~HREADY;
    assign w_req     = biu_stb_i & ~w_kill & ~rst_i;
    assign w_stb_ack = w_req & HREADY;

    // Address phase driven straight from the request
    always_comb begin
        HTRANS        = w_req ? HTRANS_NONSEQ : HTRANS_IDLE;
        HADDR         = biu_adri_i;
        HWRITE        = biu_we_i;
        HSIZE         = biu_size_i;
        HBURST        = biu_type_i;
        HPROT         = {1'b0, biu_prot_i};
        HMASTLOCK     = biu_lock_i & w_req;
        biu_stb_ack_o = w_stb_ack;
    end

    // Data phase completion and return path
    always_comb begin
        HWDATA     = r_dp_d;
        biu_adro_o = r_dp_adr;
        biu_q_o    = HRDATA;
        biu_ack_o  = r_dp_vld & HREADY & ~HRESP & ~rst_i;
        biu_err_o  = r_dp_vld & HREADY &  HRESP & ~rst_i;
    end

    // Advance the pipeline only when the bus is ready; a wait state holds everything
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_dp_vld <= 1'b0;
            r_dp_we  <= 1'b0;
            r_dp_adr <= '0;
            r_dp_d   <= '0;
        end else if (HREADY) begin
            r_dp_vld <= w_stb_ack;
            r_dp_we  <= biu_we_i;
            r_dp_adr <= biu_adri_i;
            r_dp_d   <= biu_d_i;
        end
    end

    // The write-enable of the data phase is kept for observability of the
    // return path; read data is only meaningful for completed reads.
    logic w_dp_unused;
    assign w_dp_unused = r_dp_we;

endmodule

// File: tb/tb_riscv_dbiu_ahb.sv
module tb_riscv_dbiu_ahb;
    localparam int XLEN = 64;
    localparam int PLEN = 64;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            biu_stb_i;
    logic            biu_stb_ack_o;
    logic [PLEN-1:0] biu_adri_i;
    logic [PLEN-1:0] biu_adro_o;
    logic [2:0]      biu_size_i;
    logic [2:0]      biu_type_i;
    logic            biu_lock_i;
    logic [2:0]      biu_prot_i;
    logic            biu_we_i;
    logic [XLEN-1:0] biu_d_i;
    logic [XLEN-1:0] biu_q_o;
    logic            biu_ack_o;
    logic            biu_err_o;
    logic [PLEN-1:0] HADDR;
    logic [XLEN-1:0] HWDATA;
    logic [XLEN-1:0] HRDATA;
    logic            HWRITE;
    logic [2:0]      HSIZE;
    logic [2:0]      HBURST;
    logic [3:0]      HPROT;
    logic [1:0]      HTRANS;
    logic            HMASTLOCK;
    logic            HREADY;
    logic            HRESP;

    always #5 clk_i = ~clk_i;

    riscv_dbiu_ahb #(.XLEN(XLEN), .PLEN(PLEN)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .biu_stb_i(biu_stb_i), .biu_stb_ack_o(biu_stb_ack_o),
        .biu_adri_i(biu_adri_i), .biu_adro_o(biu_adro_o),
        .biu_size_i(biu_size_i), .biu_type_i(biu_type_i),
        .biu_lock_i(biu_lock_i), .biu_prot_i(biu_prot_i),
        .biu_we_i(biu_we_i), .biu_d_i(biu_d_i), .biu_q_o(biu_q_o),
        .biu_ack_o(biu_ack_o), .biu_err_o(biu_err_o),
        .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
        .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HRESP(HRESP)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: list of transfers whose address phase was accepted
    // and whose data phase has not yet completed (front = current data phase).
    typedef struct {
        logic            we;
        logic [PLEN-1:0] adr;
        logic [XLEN-1:0] d;
    } xfer_t;
    xfer_t m_q[$];
    bit    m_zero   = 1'b0;  // data-phase outputs known to be reset values
    bit    last_acc = 1'b0;
    int    n_acks   = 0;
    int    n_errs   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: inputs already applied after the falling edge.
    task automatic step();
        bit    busy, kill, e_acc, e_ack, e_err, e_req;
        xfer_t t;
        #1;
        busy  = (m_q.size() != 0);
        kill  = busy && HRESP && !HREADY;
        e_req = !rst_i && biu_stb_i && !kill;
        e_acc = e_req && HREADY;
        e_ack = !rst_i && busy && HREADY && !HRESP;
        e_err = !rst_i && busy && HREADY && HRESP;
        chk("stb_ack", biu_stb_ack_o, e_acc);
        chk("htrans", HTRANS, e_req ? 64'd2 : 64'd0);
        chk("ack", biu_ack_o, e_ack);
        chk("err", biu_err_o, e_err);
        chk("haddr", HADDR, biu_adri_i);
        chk("hwrite", HWRITE, biu_we_i);
        chk("hsize", HSIZE, biu_size_i);
        chk("hburst", HBURST, biu_type_i);
        chk("hprot", HPROT, {1'b0, biu_prot_i});
        chk("hmastlock", HMASTLOCK, biu_lock_i && e_req);
        if (busy && !rst_i) begin
            chk("adro", biu_adro_o, m_q[0].adr);
            if (m_q[0].we) chk("hwdata", HWDATA, m_q[0].d);
            else if (e_ack) chk("rdata", biu_q_o, HRDATA);
        end else if (m_zero) begin
            chk("adro_rst", biu_adro_o, 64'd0);
            chk("hwdata_rst", HWDATA, 64'd0);
        end
        if (e_ack) n_acks++;
        if (e_err) n_errs++;
        last_acc = e_acc;
        @(posedge clk_i);
        if (rst_i) begin
            m_q.delete();
            m_zero = 1'b1;
        end else if (HREADY) begin
            m_zero = 1'b0;
            if (busy) void'(m_q.pop_front());
            if (e_acc) begin
                t.we  = biu_we_i;
                t.adr = biu_adri_i;
                t.d   = biu_d_i;
                m_q.push_back(t);
            end
        end
        @(negedge clk_i);
    endtask

    task automatic req(input logic stb, input logic [63:0] adr, input logic we,
                       input logic [63:0] d);
        biu_stb_i  = stb;
        biu_adri_i = adr;
        biu_we_i   = we;
        biu_d_i    = d;
        biu_size_i = 3'd3;
    endtask

    task automatic bus(input logic rdy, input logic resp, input logic [63:0] rdata);
        HREADY = rdy;
        HRESP  = resp;
        HRDATA = rdata;
    endtask

    initial begin
        rst_i = 1'b1;
        biu_type_i = 3'd0; biu_lock_i = 1'b0; biu_prot_i = 3'd3;
        req(1'b1, 64'h1000, 1'b0, 64'h0);
        bus(1'b1, 1'b0, 64'h0);
        @(negedge clk_i);
        // Reset holds everything quiet even with a request present
        step(); step();
        rst_i = 1'b0;

        // Single read
        req(1'b1, 64'h1000, 1'b0, 64'h0);          step();
        req(1'b0, 64'h0, 1'b0, 64'h0);
        bus(1'b1, 1'b0, 64'hDEADBEEF_CAFEF00D);     step();

        // Write with two wait states
        req(1'b1, 64'h2008, 1'b1, 64'h55);          step();
        req(1'b0, 64'h0, 1'b0, 64'h0);
        bus(1'b0, 1'b0, 64'h0);                     step(); step();
        bus(1'b1, 1'b0, 64'h0);                     step();

        // Four back-to-back reads
        for (int i = 0; i < 4; i++) begin
            req(1'b1, 64'h4000 + 64'(i * 8), 1'b0, 64'h0);
            bus(1'b1, 1'b0, 64'h1111 * 64'(i + 1));
            step();
        end
        req(1'b0, 64'h0, 1'b0, 64'h0);              step();

        // Two-cycle error with a pending request behind it
        req(1'b1, 64'h3000, 1'b0, 64'h0);           step();
        req(1'b1, 64'h3004, 1'b0, 64'h0);
        bus(1'b0, 1'b1, 64'h0);                     step();
        bus(1'b1, 1'b1, 64'h0);                     step();
        req(1'b0, 64'h0, 1'b0, 64'h0);
        bus(1'b1, 1'b0, 64'h77);                    step();

        // Reset while a data phase is stalled
        req(1'b1, 64'h5000, 1'b1, 64'hAA);          step();
        req(1'b0, 64'h0, 1'b0, 64'h0);
        bus(1'b0, 1'b0, 64'h0);                     step();
        rst_i = 1'b1;                               step();
        rst_i = 1'b0;
        bus(1'b1, 1'b0, 64'h0);                     step(); step();

        // HRESP with nothing outstanding is ignored
        bus(1'b1, 1'b1, 64'h0);                     step();
        req(1'b1, 64'h6000, 1'b0, 64'h0);           step();
        req(1'b0, 64'h0, 1'b0, 64'h0);
        bus(1'b1, 1'b0, 64'h99);                    step();

        // Randomized traffic; upstream holds a request until accepted
        for (int i = 0; i < 3000; i++) begin
            if (!biu_stb_i || last_acc || rst_i) begin
                biu_stb_i  = ($urandom_range(0, 3) != 0);
                biu_adri_i = {$urandom, $urandom};
                biu_we_i   = $urandom_range(0, 1);
                biu_d_i    = {$urandom, $urandom};
                biu_size_i = 3'($urandom_range(0, 3));
                biu_type_i = 3'($urandom_range(0, 7));
                biu_lock_i = $urandom_range(0, 1);
                biu_prot_i = 3'($urandom_range(0, 7));
            end
            HREADY = ($urandom_range(0, 9) < 7);
            HRESP  = ($urandom_range(0, 4) == 0);
            HRDATA = {$urandom, $urandom};
            rst_i  = ($urandom_range(0, 199) == 0);
            step();
        end

        chk("acks_seen", 64'(n_acks > 100), 64'd1);
        chk("errs_seen", 64'(n_errs > 10), 64'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
